// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master bus arbiter: state encoding and parameter defaults.
package bus_arbiter_pkg;

  localparam int unsigned MaxLockDefault = 16;
  localparam int unsigned DataW          = 32;
  localparam int unsigned LockCntW       = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the two master ports and the bridge request/response side of the arbiter.
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic             m0_req,    m1_req;
  logic             m0_wen,    m1_wen;
  logic [DataW-1:0] m0_addr,   m1_addr;
  logic [DataW-1:0] m0_wdata,  m1_wdata;
  logic             m0_lock,   m1_lock;
  logic             m0_gnt,    m1_gnt;
  logic             m0_rvalid, m1_rvalid;
  logic [DataW-1:0] m0_rdata,  m1_rdata;
  logic [DataW-1:0] Bus_addr;
  logic             Bus_wen;
  logic [DataW-1:0] Bus_wdata;
  logic [DataW-1:0] Bus_rdata;

  // Arbiter side
  modport slave (
    input  m0_req, m1_req, m0_wen, m1_wen, m0_addr, m1_addr,
    input  m0_wdata, m1_wdata, m0_lock, m1_lock, Bus_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    output Bus_addr, Bus_wen, Bus_wdata
  );

  // Masters plus bridge side
  modport master (
    output m0_req, m1_req, m0_wen, m1_wen, m0_addr, m1_addr,
    output m0_wdata, m1_wdata, m0_lock, m1_lock, Bus_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    input  Bus_addr, Bus_wen, Bus_wdata
  );

endinterface

// File: rtl/arb_rr_pick.sv
// Combinational two-way round-robin picker: on a tie the master not granted last wins.
module arb_rr_pick (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_gnt,
  output logic o_any,
  output logic o_win
);

  assign o_any = i_req0 | i_req1;
  assign o_win = (i_req0 & i_req1) ? ~i_last_gnt : i_req1;

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter with round-robin tie break, bounded locking and registered read return.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned MAX_LOCK = MaxLockDefault
) (
  input logic          cpu_clk,
  input logic          cpu_rst,
  bus_arbiter_if.slave bus
);

  localparam logic [LockCntW-1:0] LockLim = LockCntW'(MAX_LOCK - 1);

  arb_state_e          r_state_q, w_state_d;
  logic                r_last_gnt_q;
  logic [LockCntW-1:0] r_lock_cnt_q, w_lock_cnt_d;
  logic                r_m0_rvalid_q, r_m1_rvalid_q;
  logic [DataW-1:0]    r_m0_rdata_q, r_m1_rdata_q;

  logic w_any, w_win;
  logic w_acc0, w_acc1, w_acc_lock;

  arb_rr_pick u_pick (
    .i_req0     (bus.m0_req),
    .i_req1     (bus.m1_req),
    .i_last_gnt (r_last_gnt_q),
    .o_any      (w_any),
    .o_win      (w_win)
  );

  // Reset drives the state to idle asynchronously, so no transfer can be accepted during reset.
  assign w_acc0     = (r_state_q == StGnt0) && bus.m0_req;
  assign w_acc1     = (r_state_q == StGnt1) && bus.m1_req;
  assign w_acc_lock = (w_acc0 && bus.m0_lock) || (w_acc1 && bus.m1_lock);

  assign bus.m0_gnt    = (r_state_q == StGnt0);
  assign bus.m1_gnt    = (r_state_q == StGnt1);
  assign bus.m0_rvalid = r_m0_rvalid_q;
  assign bus.m1_rvalid = r_m1_rvalid_q;
  assign bus.m0_rdata  = r_m0_rdata_q;
  assign bus.m1_rdata  = r_m1_rdata_q;

  always_comb begin
    w_state_d = r_state_q;
    unique case (r_state_q)
      StIdle: begin
        if (w_any) w_state_d = w_win ? StGnt1 : StGnt0;
      end
      StGnt0: begin
        if (bus.m0_req) begin
          if (!(bus.m0_lock && (r_lock_cnt_q < LockLim)) && bus.m1_req) w_state_d = StGnt1;
        end else begin
          w_state_d = bus.m1_req ? StGnt1 : StIdle;
        end
      end
      StGnt1: begin
        if (bus.m1_req) begin
          if (!(bus.m1_lock && (r_lock_cnt_q < LockLim)) && bus.m0_req) w_state_d = StGnt0;
        end else begin
          w_state_d = bus.m0_req ? StGnt0 : StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_lock_cnt_d = r_lock_cnt_q;
    if (w_state_d != r_state_q) begin
      w_lock_cnt_d = '0;
    end else if (w_acc0 || w_acc1) begin
      w_lock_cnt_d = w_acc_lock ? r_lock_cnt_q + 1'b1 : '0;
    end
  end

  always_comb begin
    bus.Bus_addr  = '0;
    bus.Bus_wen   = 1'b0;
    bus.Bus_wdata = '0;
    if (w_acc0) begin
      bus.Bus_addr  = bus.m0_addr;
      bus.Bus_wen   = bus.m0_wen;
      bus.Bus_wdata = bus.m0_wdata;
    end else if (w_acc1) begin
      bus.Bus_addr  = bus.m1_addr;
      bus.Bus_wen   = bus.m1_wen;
      bus.Bus_wdata = bus.m1_wdata;
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state_q     <= StIdle;
      r_last_gnt_q  <= 1'b1;
      r_lock_cnt_q  <= '0;
      r_m0_rvalid_q <= 1'b0;
      r_m1_rvalid_q <= 1'b0;
      r_m0_rdata_q  <= '0;
      r_m1_rdata_q  <= '0;
    end else begin
      r_state_q     <= w_state_d;
      r_lock_cnt_q  <= w_lock_cnt_d;
      r_m0_rvalid_q <= w_acc0 && !bus.m0_wen;
      r_m1_rvalid_q <= w_acc1 && !bus.m1_wen;
      if (w_acc0) r_last_gnt_q <= 1'b0;
      else if (w_acc1) r_last_gnt_q <= 1'b1;
      if (w_acc0 && !bus.m0_wen) r_m0_rdata_q <= bus.Bus_rdata;
      if (w_acc1 && !bus.m1_wen) r_m1_rdata_q <= bus.Bus_rdata;
    end
  end

endmodule
